// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives SYNC/ADDR/DATA/CSUM packets from a UART receive FIFO and writes
//   them into program memory while holding the CPU in reset. An END_BYTE seen
//   between packets finishes the load and releases the CPU.
//
// Optional feature macro: UART_LOADER_RESP_EN
//   defined   -> an ACK (8'h06) or NAK (8'h15) byte is pushed to the transmit
//                FIFO after every packet that reaches the checksum byte.
//   undefined -> no responses; tx_data_out and write_tx_data are tied low.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset (release synchronised)
//   rx_data_in       byte at head of receive FIFO
//   rx_data_present  receive FIFO non-empty
//   read_rx_data_ack one-cycle pop strobe to receive FIFO
//   tx_data_out      response byte to transmit FIFO
//   write_tx_data    one-cycle push strobe to transmit FIFO
//   tx_buffer_full   transmit FIFO full
//   mem_addr         program-memory write address (holds last write)
//   mem_wdata        program-memory write data (holds last write)
//   mem_we           one-cycle program-memory write strobe
//   cpu_hold         CPU reset hold, low only once loading is done
//   load_done        sticky end-of-load flag
//   err_count        saturating count of rejected packets
module uart_prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  END_BYTE       = 8'h5A,
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data_in,
    input  logic       rx_data_present,
    output logic       read_rx_data_ack,
    output logic [7:0] tx_data_out,
    output logic       write_tx_data,
    input  logic       tx_buffer_full,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       cpu_hold,
    output logic       load_done,
    output logic [7:0] err_count
);

    localparam int unsigned    TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CSUM, S_WRITE, S_DONE
`ifdef UART_LOADER_RESP_EN
        , S_RESP
`endif
    } state_t;

    // Reset asserts asynchronously, releases two clocks after reset rises.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      err_q, err_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic            ack_q, ack_d;
    logic            load_done_q, load_done_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic [7:0]      resp_q, resp_d;

    logic            take;
    logic            timeout;
    logic            err_inc;
    logic [7:0]      csum_exp;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        load_done_d = load_done_q;
        tx_data_d   = tx_data_q;
        tx_wr_d     = 1'b0;
        resp_d      = resp_q;
        err_inc     = 1'b0;
        csum_exp    = addr_q + data_q;

        // Pop at most every other cycle: the FIFO head only advances after
        // the cycle in which the ack is seen.
        take    = rx_data_present && !ack_q &&
                  (state_q inside {S_IDLE, S_ADDR, S_DATA, S_CSUM});
        ack_d   = take;
        timeout = (timer_q >= TIMER_LAST);

        if (state_q == S_IDLE || take)
            timer_d = '0;
        else if (state_q inside {S_ADDR, S_DATA, S_CSUM})
            timer_d = timer_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    if (rx_data_in == SYNC_BYTE) begin
                        state_d = S_ADDR;
                    end else if (rx_data_in == END_BYTE) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (take) begin
                    if (state_q == S_ADDR) begin
                        addr_d  = rx_data_in;
                        state_d = S_DATA;
                    end else begin
                        data_d  = rx_data_in;
                        state_d = S_CSUM;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    err_inc = 1'b1;
                end
            end
            S_CSUM: begin
                if (take) begin
                    if (rx_data_in == csum_exp) begin
                        mem_addr_d  = addr_q;
                        mem_wdata_d = data_q;
                        mem_we_d    = 1'b1;
                        state_d     = S_WRITE;
                    end else begin
                        err_inc = 1'b1;
`ifdef UART_LOADER_RESP_EN
                        resp_d  = 8'h15;
                        state_d = S_RESP;
`else
                        state_d = S_IDLE;
`endif
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    err_inc = 1'b1;
                end
            end
            S_WRITE: begin
`ifdef UART_LOADER_RESP_EN
                resp_d  = 8'h06;
                state_d = S_RESP;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef UART_LOADER_RESP_EN
            S_RESP: begin
                if (!tx_buffer_full) begin
                    tx_data_d = resp_q;
                    tx_wr_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`endif
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        err_d      = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            err_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            ack_q       <= 1'b0;
            load_done_q <= 1'b0;
            cpu_hold_q  <= 1'b1;
            tx_data_q   <= '0;
            tx_wr_q     <= 1'b0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            ack_q       <= ack_d;
            load_done_q <= load_done_d;
            cpu_hold_q  <= cpu_hold_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
            resp_q      <= resp_d;
        end
    end

    assign read_rx_data_ack = ack_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_we           = mem_we_q;
    assign cpu_hold         = cpu_hold_q;
    assign load_done        = load_done_q;
    assign err_count        = err_q;

`ifdef UART_LOADER_RESP_EN
    assign tx_data_out   = tx_data_q;
    assign write_tx_data = tx_wr_q;
`else
    // Response path absent: the tx registers stay at reset value.
    logic unused_resp;
    assign unused_resp   = tx_buffer_full ^ tx_wr_q ^ (^tx_data_q) ^ (^resp_q);
    assign tx_data_out   = '0;
    assign write_tx_data = 1'b0;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a small receive-FIFO model.
module tb_uart_prog_loader;

    localparam int unsigned TO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data_in = 8'h00;
    logic       rx_data_present = 1'b0;
    logic       read_rx_data_ack;
    logic [7:0] tx_data_out;
    logic       write_tx_data;
    logic       tx_buffer_full = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_hold;
    logic       load_done;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .SYNC_BYTE      (8'hA5),
        .END_BYTE       (8'h5A),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data_in       (rx_data_in),
        .rx_data_present  (rx_data_present),
        .read_rx_data_ack (read_rx_data_ack),
        .tx_data_out      (tx_data_out),
        .write_tx_data    (write_tx_data),
        .tx_buffer_full   (tx_buffer_full),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .cpu_hold         (cpu_hold),
        .load_done        (load_done),
        .err_count        (err_count)
    );

    int checks = 0;
    int fails  = 0;

    logic [7:0] rxq[$];
    int         we_cnt = 0, tx_cnt = 0, pop_cnt = 0, consec = 0;
    logic [7:0] last_addr = 8'h00, last_data = 8'h00, last_tx = 8'h00;
    logic       prev_ack = 1'b0;

    // Receive FIFO model plus event monitor, all on the falling edge.
    always @(negedge clk) begin
        if (read_rx_data_ack === 1'b1) begin
            pop_cnt++;
            if (prev_ack) consec++;
            if (rxq.size() != 0) void'(rxq.pop_front());
        end
        prev_ack = (read_rx_data_ack === 1'b1);
        if (mem_we === 1'b1) begin
            we_cnt++;
            last_addr = mem_addr;
            last_data = mem_wdata;
        end
        if (write_tx_data === 1'b1) begin
            tx_cnt++;
            last_tx = tx_data_out;
        end
        rx_data_present = (rxq.size() != 0);
        rx_data_in      = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        rxq.push_back(b0);
        rxq.push_back(b1);
        rxq.push_back(b2);
        rxq.push_back(b3);
    endtask

    task automatic wait_rx_empty(input int maxc);
        int n = 0;
        while (rxq.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (rxq.size() != 0) begin
            checks++; fails++;
            $display("FAIL rx_drain: %0d bytes left, want 0", rxq.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks += 9;
        if (cpu_hold !== 1'b1)         begin fails++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        if (load_done !== 1'b0)        begin fails++; $display("FAIL rst_load_done: got %b want 0", load_done); end
        if (err_count !== 8'h00)       begin fails++; $display("FAIL rst_err: got %h want 00", err_count); end
        if (mem_we !== 1'b0)           begin fails++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        if (read_rx_data_ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b want 0", read_rx_data_ack); end
        if (write_tx_data !== 1'b0)    begin fails++; $display("FAIL rst_txwr: got %b want 0", write_tx_data); end
        if (mem_addr !== 8'h00)        begin fails++; $display("FAIL rst_addr: got %h want 00", mem_addr); end
        if (mem_wdata !== 8'h00)       begin fails++; $display("FAIL rst_wdata: got %h want 00", mem_wdata); end
        if (tx_data_out !== 8'h00)     begin fails++; $display("FAIL rst_txdata: got %h want 00", tx_data_out); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_valid_packet;
        int we0 = we_cnt, tx0 = tx_cnt;
        push4(8'hA5, 8'h10, 8'h3C, 8'h4C);
        wait_rx_empty(50);
        repeat (8) @(negedge clk);
        checks += 6;
        if (we_cnt - we0 !== 1)  begin fails++; $display("FAIL valid_we_pulses: got %0d want 1", we_cnt - we0); end
        if (last_addr !== 8'h10) begin fails++; $display("FAIL valid_addr: got %h want 10", last_addr); end
        if (last_data !== 8'h3C) begin fails++; $display("FAIL valid_data: got %h want 3c", last_data); end
        if (mem_addr !== 8'h10)  begin fails++; $display("FAIL valid_addr_hold: got %h want 10", mem_addr); end
        if (err_count !== 8'h00) begin fails++; $display("FAIL valid_err: got %h want 00", err_count); end
        if (cpu_hold !== 1'b1)   begin fails++; $display("FAIL valid_cpu_hold: got %b want 1", cpu_hold); end
`ifdef UART_LOADER_RESP_EN
        checks += 2;
        if (tx_cnt - tx0 !== 1) begin fails++; $display("FAIL valid_tx_pushes: got %0d want 1", tx_cnt - tx0); end
        if (last_tx !== 8'h06)  begin fails++; $display("FAIL valid_tx_byte: got %h want 06", last_tx); end
`else
        checks++;
        if (tx_cnt - tx0 !== 0) begin fails++; $display("FAIL valid_tx_pushes: got %0d want 0", tx_cnt - tx0); end
`endif
    endtask

    task automatic test_bad_csum;
        int we0 = we_cnt, tx0 = tx_cnt;
        push4(8'hA5, 8'h10, 8'h3C, 8'h4D);
        wait_rx_empty(50);
        repeat (8) @(negedge clk);
        checks += 3;
        if (we_cnt - we0 !== 0)  begin fails++; $display("FAIL bad_we_pulses: got %0d want 0", we_cnt - we0); end
        if (err_count !== 8'h01) begin fails++; $display("FAIL bad_err: got %h want 01", err_count); end
        if (mem_wdata !== 8'h3C) begin fails++; $display("FAIL bad_wdata_hold: got %h want 3c", mem_wdata); end
`ifdef UART_LOADER_RESP_EN
        checks += 2;
        if (tx_cnt - tx0 !== 1) begin fails++; $display("FAIL bad_tx_pushes: got %0d want 1", tx_cnt - tx0); end
        if (last_tx !== 8'h15)  begin fails++; $display("FAIL bad_tx_byte: got %h want 15", last_tx); end
`else
        checks++;
        if (tx_cnt - tx0 !== 0) begin fails++; $display("FAIL bad_tx_pushes: got %0d want 0", tx_cnt - tx0); end
`endif
    endtask

    task automatic test_timeout;
        int we0 = we_cnt, tx0 = tx_cnt;
        rxq.push_back(8'hA5);
        rxq.push_back(8'h20);
        wait_rx_empty(20);
        repeat (TO + 4) @(negedge clk);
        checks += 3;
        if (err_count !== 8'h02) begin fails++; $display("FAIL to_err: got %h want 02", err_count); end
        if (tx_cnt - tx0 !== 0)  begin fails++; $display("FAIL to_tx_pushes: got %0d want 0", tx_cnt - tx0); end
        if (we_cnt - we0 !== 0)  begin fails++; $display("FAIL to_we_pulses: got %0d want 0", we_cnt - we0); end
        // Address FF with data 01 wraps the checksum to 00.
        push4(8'hA5, 8'hFF, 8'h01, 8'h00);
        wait_rx_empty(50);
        repeat (8) @(negedge clk);
        checks += 4;
        if (we_cnt - we0 !== 1)  begin fails++; $display("FAIL to_next_we: got %0d want 1", we_cnt - we0); end
        if (last_addr !== 8'hFF) begin fails++; $display("FAIL to_next_addr: got %h want ff", last_addr); end
        if (last_data !== 8'h01) begin fails++; $display("FAIL to_next_data: got %h want 01", last_data); end
        if (err_count !== 8'h02) begin fails++; $display("FAIL to_next_err: got %h want 02", err_count); end
    endtask

    task automatic test_tx_full;
`ifdef UART_LOADER_RESP_EN
        int tx0 = tx_cnt, pop0 = pop_cnt, we0 = we_cnt;
        tx_buffer_full = 1'b1;
        push4(8'hA5, 8'h42, 8'h11, 8'h53);
        rxq.push_back(8'h33);
        repeat (50) @(negedge clk);
        checks += 4;
        if (tx_cnt - tx0 !== 0)   begin fails++; $display("FAIL full_tx_held: got %0d want 0", tx_cnt - tx0); end
        if (pop_cnt - pop0 !== 4) begin fails++; $display("FAIL full_pops: got %0d want 4", pop_cnt - pop0); end
        if (rxq.size() !== 1)     begin fails++; $display("FAIL full_rxq: got %0d want 1", rxq.size()); end
        if (we_cnt - we0 !== 1)   begin fails++; $display("FAIL full_we: got %0d want 1", we_cnt - we0); end
        tx_buffer_full = 1'b0;
        repeat (10) @(negedge clk);
        checks += 3;
        if (tx_cnt - tx0 !== 1) begin fails++; $display("FAIL full_tx_after: got %0d want 1", tx_cnt - tx0); end
        if (last_tx !== 8'h06)  begin fails++; $display("FAIL full_tx_byte: got %h want 06", last_tx); end
        if (rxq.size() !== 0)   begin fails++; $display("FAIL full_rxq_after: got %0d want 0", rxq.size()); end
`endif
    endtask

    task automatic test_reset_mid_packet;
        int we0, tx0;
        rxq.push_back(8'hA5);
        rxq.push_back(8'h30);
        rxq.push_back(8'h44);
        wait_rx_empty(30);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks += 9;
        if (cpu_hold !== 1'b1)         begin fails++; $display("FAIL mid_cpu_hold: got %b want 1", cpu_hold); end
        if (load_done !== 1'b0)        begin fails++; $display("FAIL mid_load_done: got %b want 0", load_done); end
        if (err_count !== 8'h00)       begin fails++; $display("FAIL mid_err: got %h want 00", err_count); end
        if (mem_we !== 1'b0)           begin fails++; $display("FAIL mid_mem_we: got %b want 0", mem_we); end
        if (read_rx_data_ack !== 1'b0) begin fails++; $display("FAIL mid_ack: got %b want 0", read_rx_data_ack); end
        if (write_tx_data !== 1'b0)    begin fails++; $display("FAIL mid_txwr: got %b want 0", write_tx_data); end
        if (mem_addr !== 8'h00)        begin fails++; $display("FAIL mid_addr: got %h want 00", mem_addr); end
        if (mem_wdata !== 8'h00)       begin fails++; $display("FAIL mid_wdata: got %h want 00", mem_wdata); end
        if (tx_data_out !== 8'h00)     begin fails++; $display("FAIL mid_txdata: got %h want 00", tx_data_out); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        we0 = we_cnt;
        tx0 = tx_cnt;
        // The would-be checksum (30+44=74) arrives in IDLE and is discarded.
        rxq.push_back(8'h74);
        wait_rx_empty(20);
        repeat (8) @(negedge clk);
        checks += 3;
        if (we_cnt - we0 !== 0)  begin fails++; $display("FAIL mid_after_we: got %0d want 0", we_cnt - we0); end
        if (tx_cnt - tx0 !== 0)  begin fails++; $display("FAIL mid_after_tx: got %0d want 0", tx_cnt - tx0); end
        if (err_count !== 8'h00) begin fails++; $display("FAIL mid_after_err: got %h want 00", err_count); end
    endtask

    task automatic test_done;
        int pop0;
        rxq.push_back(8'h33);
        rxq.push_back(8'h5A);
        wait_rx_empty(20);
        repeat (4) @(negedge clk);
        checks += 3;
        if (load_done !== 1'b1)  begin fails++; $display("FAIL done_load_done: got %b want 1", load_done); end
        if (cpu_hold !== 1'b0)   begin fails++; $display("FAIL done_cpu_hold: got %b want 0", cpu_hold); end
        if (err_count !== 8'h00) begin fails++; $display("FAIL done_err: got %h want 00", err_count); end
        pop0 = pop_cnt;
        rxq.push_back(8'hA5);
        repeat (12) @(negedge clk);
        checks += 4;
        if (pop_cnt - pop0 !== 0) begin fails++; $display("FAIL done_pops: got %0d want 0", pop_cnt - pop0); end
        if (rxq.size() !== 1)     begin fails++; $display("FAIL done_rxq: got %0d want 1", rxq.size()); end
        if (cpu_hold !== 1'b0)    begin fails++; $display("FAIL done_hold_stays: got %b want 0", cpu_hold); end
        if (load_done !== 1'b1)   begin fails++; $display("FAIL done_sticky: got %b want 1", load_done); end
    endtask

    initial begin
        test_reset;
        test_valid_packet;
        test_bad_csum;
        test_timeout;
        test_tx_full;
        test_reset_mid_packet;
        test_done;
        checks++;
        if (consec !== 0) begin fails++; $display("FAIL ack_back_to_back: got %0d want 0", consec); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
